pattern_tx: RTL and testbench

Serial frame transmitter that produces the bitstream consumed by the team's "101" sequence detectors. It accepts a parallel payload word over a valid/ready handshake, emits the 3-bit preamble `101`, then the payload MSB-first. It inserts stuff bits so that `101` never appears anywhere in the frame except the preamble. It sits on the driving side of the single-bit serial line (`x`) that feeds the detector.

---
 rtl/pattern_tx_if.sv | 25 ++
 rtl/pattern_tx.sv | 143 ++++++++++++++
 tb/tb_pattern_tx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pattern_tx_if.sv
// pattern_tx_if: payload handshake and serial-line bundle for pattern_tx.
//   in_valid / in_ready / in_data : parallel payload word handshake (master -> slave)
//   x / x_en                      : serial bit and its qualifier (slave -> master)
//   busy / done                   : frame-in-progress flag and end-of-frame pulse
interface pattern_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              x;
    logic              x_en;
    logic              busy;
    logic              done;

    modport master (
        output in_valid, in_data,
        input  in_ready, x, x_en, busy, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, x, x_en, busy, done
    );
endinterface

// File: rtl/pattern_tx.sv
// pattern_tx: serial frame transmitter. It sends the 3-bit preamble and then
// the payload MSB-first, inserting a 0 after every emitted "10". The pattern
// "101" therefore appears only in the preamble.
//   clk, rst : clock and synchronous active-high reset
//   bus      : pattern_tx_if.slave (handshake in, serial line and status out)
module pattern_tx #(
    parameter int unsigned DATA_W = 8,
    parameter logic [2:0]  PRE    = 3'b101,
    parameter int unsigned GAP    = 2
) (
    input  logic         clk,
    input  logic         rst,
    pattern_tx_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]        state,   state_nxt;
    logic [DATA_W-1:0] sr,      sr_nxt;
    logic [CNT_W-1:0]  cnt,     cnt_nxt;
    logic [1:0]        h,       h_nxt;
    logic [1:0]        pre_idx, pre_idx_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic              x_q,     x_nxt;
    logic              x_en_q,  x_en_nxt;
    logic              busy_q,  busy_nxt;
    logic              done_q,  done_nxt;
    logic              data_step;
    logic              in_ready_c;

    assign in_ready_c   = (state == S_IDLE) && !rst;
    assign bus.in_ready = in_ready_c;
    assign bus.x        = x_q;
    assign bus.x_en     = x_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            sr      <= '0;
            cnt     <= '0;
            h       <= '0;
            pre_idx <= '0;
            gap_cnt <= '0;
            x_q     <= 1'b0;
            x_en_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            sr      <= sr_nxt;
            cnt     <= cnt_nxt;
            h       <= h_nxt;
            pre_idx <= pre_idx_nxt;
            gap_cnt <= gap_cnt_nxt;
            x_q     <= x_nxt;
            x_en_q  <= x_en_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next state and the bit to drive on x in the following cycle.
    // x_q holds the bit currently on the line; h holds the last two bits sent.
    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        cnt_nxt     = cnt;
        h_nxt       = h;
        pre_idx_nxt = pre_idx;
        gap_cnt_nxt = gap_cnt;
        x_nxt       = 1'b0;
        x_en_nxt    = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        data_step   = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.in_valid && in_ready_c) begin
                    state_nxt   = S_PRE;
                    sr_nxt      = bus.in_data;
                    cnt_nxt     = CNT_W'(DATA_W);
                    pre_idx_nxt = 2'd0;
                    h_nxt       = {1'b0, PRE[2]};
                    x_nxt       = PRE[2];
                    x_en_nxt    = 1'b1;
                    busy_nxt    = 1'b1;
                end
            end
            S_PRE: begin
                busy_nxt = 1'b1;
                if (pre_idx == 2'd2) begin
                    data_step = 1'b1;
                end else begin
                    pre_idx_nxt = pre_idx + 2'd1;
                    x_nxt       = (pre_idx == 2'd0) ? PRE[1] : PRE[0];
                    x_en_nxt    = 1'b1;
                    h_nxt       = {h[0], x_nxt};
                end
            end
            S_DATA: begin
                data_step = 1'b1;
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP - 1)) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                    busy_nxt    = 1'b1;
                end
            end
        endcase

        // One payload-phase slot: finish, stuff a 0 after "10", or send the next bit.
        if (data_step) begin
            busy_nxt  = 1'b1;
            state_nxt = S_DATA;
            if (cnt == '0 && h != 2'b10) begin
                state_nxt   = S_GAP;
                gap_cnt_nxt = '0;
                done_nxt    = 1'b1;
            end else if (h == 2'b10) begin
                x_nxt    = 1'b0;
                x_en_nxt = 1'b1;
                h_nxt    = 2'b00;
            end else begin
                x_nxt    = sr[DATA_W-1];
                x_en_nxt = 1'b1;
                sr_nxt   = sr << 1;
                cnt_nxt  = cnt - CNT_W'(1);
                h_nxt    = {h[0], sr[DATA_W-1]};
            end
        end
    end
endmodule

// File: tb/tb_pattern_tx.sv
module tb_pattern_tx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pattern_tx_if #(.DATA_W(8)) bus();

    pattern_tx #(.DATA_W(8), .PRE(3'b101), .GAP(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Offer a word from a negedge and return at the negedge after the handshake edge.
    task automatic handshake(input logic [7:0] d, input bit hold, output bit ok);
        ok = 1'b0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        if (!hold) bus.in_valid = 1'b0;
    endtask

    // Collect x while x_en is high; returns at the first negedge with x_en low.
    task automatic capture(output int len, output logic [31:0] bits);
        len  = 0;
        bits = '0;
        while (bus.x_en === 1'b1 && len < 40) begin
            bits = {bits[30:0], bus.x};
            len++;
            @(negedge clk);
        end
    endtask

    // Occurrences of 101 in the frame surrounded by idle zeros.
    function automatic int count101(input logic [31:0] b, input int len);
        logic [39:0] v;
        int n;
        v = 40'(b) << 2;
        n = 0;
        for (int i = 0; i <= len + 1; i++) begin
            if (3'(v >> i) == 3'b101) n++;
        end
        return n;
    endfunction

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(posedge clk); @(posedge clk); @(negedge clk);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_low got=%b exp=0", bus.in_ready); end
        rst = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_release got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        handshake(8'hFF, 1'b0, ok);
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        tests++; if ({bus.x, bus.x_en, bus.busy, bus.done} !== 4'b0000) begin
            fails++; $display("FAIL reset_outputs got x/x_en/busy/done=%b exp=0000", {bus.x, bus.x_en, bus.busy, bus.done}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_hold_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
        end
        rst = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_mid_release_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_ff();
        bit ok; int len; logic [31:0] bits;
        handshake(8'hFF, 1'b0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL ff_handshake got=timeout exp=accepted"); end
        tests++; if ({bus.in_ready, bus.busy, bus.x, bus.x_en} !== 4'b0111) begin
            fails++; $display("FAIL ff_first_cycle got ready/busy/x/x_en=%b exp=0111", {bus.in_ready, bus.busy, bus.x, bus.x_en}); end
        capture(len, bits);
        tests++; if (len != 11) begin fails++; $display("FAIL ff_len got=%0d exp=11", len); end
        tests++; if (bits !== 32'b10111111111) begin fails++; $display("FAIL ff_bits got=%b exp=%b", bits, 32'b10111111111); end
        tests++; if ({bus.done, bus.x, bus.busy} !== 3'b101) begin
            fails++; $display("FAIL ff_gap1 got done/x/busy=%b exp=101", {bus.done, bus.x, bus.busy}); end
        @(negedge clk);
        tests++; if ({bus.done, bus.x_en, bus.busy, bus.in_ready} !== 4'b0010) begin
            fails++; $display("FAIL ff_gap2 got done/x_en/busy/ready=%b exp=0010", {bus.done, bus.x_en, bus.busy, bus.in_ready}); end
        @(negedge clk);
        tests++; if ({bus.busy, bus.in_ready, bus.x_en} !== 3'b010) begin
            fails++; $display("FAIL ff_idle got busy/ready/x_en=%b exp=010", {bus.busy, bus.in_ready, bus.x_en}); end
    endtask

    task automatic test_zero();
        bit ok; int len; logic [31:0] bits;
        handshake(8'h00, 1'b0, ok);
        capture(len, bits);
        tests++; if (len != 12) begin fails++; $display("FAIL zero_len got=%0d exp=12", len); end
        tests++; if (bits !== 32'b101000000000) begin fails++; $display("FAIL zero_bits got=%b exp=%b", bits, 32'b101000000000); end
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL zero_done got=%b exp=1", bus.done); end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_aa();
        bit ok; int len; logic [31:0] bits;
        handshake(8'hAA, 1'b0, ok);
        capture(len, bits);
        tests++; if (len != 15) begin fails++; $display("FAIL aa_len got=%0d exp=15", len); end
        tests++; if (bits !== 32'b101100100100100) begin fails++; $display("FAIL aa_bits got=%b exp=%b", bits, 32'b101100100100100); end
        tests++; if (count101(bits, len) != 1) begin fails++; $display("FAIL aa_detect got=%0d exp=1", count101(bits, len)); end
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL aa_done got=%b exp=1", bus.done); end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok; int len; logic [31:0] bits;
        handshake(8'h55, 1'b1, ok);
        bus.in_data = 8'h00;
        capture(len, bits);
        tests++; if (len != 15 || bits !== 32'b101001001001001) begin
            fails++; $display("FAIL b2b_frame1 got len=%0d bits=%b exp len=15 bits=%b", len, bits, 32'b101001001001001); end
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL b2b_done1 got=%b exp=1", bus.done); end
        bus.in_data = 8'h55;
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_gap2_ready got=%b exp=0", bus.in_ready); end
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle_ready got=%b exp=1", bus.in_ready); end
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        tests++; if ({bus.x_en, bus.x, bus.in_ready} !== 3'b110) begin
            fails++; $display("FAIL b2b_second_start got x_en/x/ready=%b exp=110", {bus.x_en, bus.x, bus.in_ready}); end
        capture(len, bits);
        tests++; if (len != 15 || bits !== 32'b101001001001001) begin
            fails++; $display("FAIL b2b_frame2 got len=%0d bits=%b exp len=15 bits=%b", len, bits, 32'b101001001001001); end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok; bit bad; int len; logic [31:0] bits;
        handshake(8'hAA, 1'b0, ok);
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done !== 1'b0 || bus.x_en !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        tests++; if (bad) begin fails++; $display("FAIL rstmid_truncate got=activity exp=no done/x_en"); end
        handshake(8'h55, 1'b0, ok);
        capture(len, bits);
        tests++; if (len != 15 || bits !== 32'b101001001001001) begin
            fails++; $display("FAIL rstmid_next got len=%0d bits=%b exp len=15 bits=%b", len, bits, 32'b101001001001001); end
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL rstmid_done got=%b exp=1", bus.done); end
        @(negedge clk); @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ff();
        test_zero();
        test_aa();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
